// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and helpers for the 1024x59 single-port SRAM access controller.
// Holds the FSM state type, the RAM write-lane boundaries and the lane mask check.
package ct_spsram_ctrl_pkg;

    localparam int unsigned DATA_W    = 59;
    localparam int unsigned LANE0_BIT = 58;
    localparam int unsigned LANE1_HI  = 57;
    localparam int unsigned LANE1_LO  = 29;
    localparam int unsigned LANE2_HI  = 28;
    localparam int unsigned LANE2_LO  = 0;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // The RAM only has one write enable per lane, so a mask is honourable
    // only if every lane is uniformly enabled or uniformly disabled.
    // Lane 0 is a single bit and is always uniform.
    function automatic logic lane_mask_ok(input logic [DATA_W-1:0] mask);
        logic [LANE1_HI-LANE1_LO:0] w_l1;
        logic [LANE2_HI-LANE2_LO:0] w_l2;
        w_l1 = mask[LANE1_HI:LANE1_LO];
        w_l2 = mask[LANE2_HI:LANE2_LO];
        return ((w_l1 == '0) || (w_l1 == '1)) && ((w_l2 == '0) || (w_l2 == '1));
    endfunction

endpackage

// File: rtl/ct_spsram_rd_rsp.sv
// Read response stage: one flop marks a pending read, the next captures RAM Q.
// Read data is held until the next response.
module ct_spsram_rd_rsp #(
    parameter int unsigned DATA_WIDTH = 59
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rd_acc,
    input  logic [DATA_WIDTH-1:0] i_ram_q,
    output logic                  o_rsp_vld,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata
);

    logic                  r_rd_pend;
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pend   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rd_pend <= i_rd_acc;
            r_rsp_vld <= r_rd_pend;
            if (r_rd_pend) begin
                r_rsp_rdata <= i_ram_q;
            end
        end
    end

    assign o_rsp_vld   = r_rsp_vld;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: rtl/ct_spsram_1024x59_ctrl.sv
// Access controller for the 1024x59 single-port SRAM: init sweep, valid/ready
// client port with one read or masked write per cycle, registered read response.
module ct_spsram_1024x59_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_start,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mask_err,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_cen,
    output logic [DATA_WIDTH-1:0] ram_d,
    output logic                  ram_gwen,
    output logic [DATA_WIDTH-1:0] ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] r_hold_a;
    logic                  r_req_rdy;
    logic                  r_init_done;
    logic                  r_mask_err;

    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    assign w_accept = req_vld & r_req_rdy;
    assign w_rd_acc = w_accept & ~req_wr;
    assign w_wr_acc = w_accept & req_wr;

    // Controller FSM, init counter and registered status outputs
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_hold_a    <= '0;
            r_req_rdy   <= 1'b0;
            r_init_done <= 1'b0;
            r_mask_err  <= 1'b0;
        end else begin
            r_mask_err <= w_wr_acc & ~lane_mask_ok(req_wmask);
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
                    r_hold_a   <= r_init_cnt;
                    if (r_init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state     <= ST_READY;
                        r_req_rdy   <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_accept) begin
                        r_hold_a <= req_addr;
                    end
                    if (init_start) begin
                        r_state     <= ST_INIT;
                        r_init_cnt  <= '0;
                        r_req_rdy   <= 1'b0;
                        r_init_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // RAM-side mux; when idle the address is held so Q stays stable
    always_comb begin
        ram_cen  = 1'b1;
        ram_gwen = 1'b1;
        ram_wen  = '1;
        ram_a    = r_hold_a;
        ram_d    = req_wdata;
        if (r_state == ST_INIT) begin
            ram_cen  = 1'b0;
            ram_gwen = 1'b0;
            ram_wen  = '0;
            ram_a    = r_init_cnt;
            ram_d    = INIT_VAL;
        end else if (w_accept) begin
            ram_cen = 1'b0;
            ram_a   = req_addr;
            if (req_wr) begin
                ram_gwen = 1'b0;
                ram_wen  = ~req_wmask;
            end
        end
    end

    ct_spsram_rd_rsp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_rsp (
        .i_clk       (forever_cpuclk),
        .i_rst_n     (cpurst_b),
        .i_rd_acc    (w_rd_acc),
        .i_ram_q     (ram_q),
        .o_rsp_vld   (rsp_vld),
        .o_rsp_rdata (rsp_rdata)
    );

    assign req_rdy   = r_req_rdy;
    assign init_done = r_init_done;
    assign mask_err  = r_mask_err;

endmodule

// File: tb/tb_ct_spsram_1024x59_ctrl.sv
// Bench for ct_spsram_1024x59_ctrl: lane-enabled SRAM model, transaction-level
// reference memory, directed vector table, multi-cycle corner sequences, random traffic.
module tb_ct_spsram_1024x59_ctrl;

    localparam int unsigned   AW       = 10;
    localparam int unsigned   DW       = 59;
    localparam int            DEPTH    = 1024;
    localparam logic [DW-1:0] INIT_VAL = '0;

    logic          clk;
    logic          rst_n;
    logic          init_start;
    logic          init_done;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rsp_vld;
    logic [DW-1:0] rsp_rdata;
    logic          mask_err;
    logic [AW-1:0] ram_a;
    logic          ram_cen;
    logic [DW-1:0] ram_d;
    logic          ram_gwen;
    logic [DW-1:0] ram_wen;
    logic [DW-1:0] ram_q;

    ct_spsram_1024x59_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VAL   (INIT_VAL)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .init_start     (init_start),
        .init_done      (init_done),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdata      (rsp_rdata),
        .mask_err       (mask_err),
        .ram_a          (ram_a),
        .ram_cen        (ram_cen),
        .ram_d          (ram_d),
        .ram_gwen       (ram_gwen),
        .ram_wen        (ram_wen),
        .ram_q          (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: one write enable per lane (WEN bits 58, 57, 28), Q registered on reads
    logic [DW-1:0] ram_mem [DEPTH];
    initial ram_q = '0;
    always @(posedge clk) begin
        if (!ram_cen) begin
            if (!ram_gwen) begin
                if (!ram_wen[58]) ram_mem[ram_a][58]    <= ram_d[58];
                if (!ram_wen[57]) ram_mem[ram_a][57:29] <= ram_d[57:29];
                if (!ram_wen[28]) ram_mem[ram_a][28:0]  <= ram_d[28:0];
            end else begin
                ram_q <= ram_mem[ram_a];
            end
        end
    end

    // Reference state
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] exp_mem [DEPTH];
    rsp_t          rsp_q[$];
    int            merr_q[$];
    logic [DW-1:0] exp_last;
    logic          exp_rdy;
    int            init_left;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic mask_uniform(input logic [DW-1:0] m);
        for (int b = 29; b <= 57; b++) if (m[b] != m[57]) return 1'b0;
        for (int b = 0; b <= 28; b++) if (m[b] != m[28]) return 1'b0;
        return 1'b1;
    endfunction

    // A bit lands only if the mask bit that controls its lane is set
    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        int ctl;
        for (int b = 0; b < DW; b++) begin
            ctl = (b == 58) ? 58 : ((b >= 29) ? 57 : 28);
            if (m[ctl]) exp_mem[a][b] = d[b];
        end
    endtask

    task automatic model_reset();
        exp_rdy   = 1'b0;
        init_left = DEPTH;
        exp_last  = '0;
        rsp_q.delete();
        merr_q.delete();
    endtask

    // One clock cycle: drive, check at negedge, advance the reference, step past posedge
    task automatic cycle(input logic vld, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask,
                         input logic start, input logic use_tbl,
                         input logic [DW-1:0] tbl_rdata, input logic tbl_merr);
        logic e_vld;
        logic e_merr;
        int   idx;
        rsp_t r;
        req_vld    = vld;
        req_wr     = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wmask  = wmask;
        init_start = start;
        @(negedge clk);
        chk("req_rdy", 136'(req_rdy), 136'(exp_rdy));
        chk("init_done", 136'(init_done), 136'(exp_rdy));
        e_vld = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
        if (e_vld) begin
            exp_last = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        chk("rsp_vld", 136'(rsp_vld), 136'(e_vld));
        chk("rsp_rdata", 136'(rsp_rdata), 136'(exp_last));
        e_merr = (merr_q.size() > 0) && (merr_q[0] == cyc);
        if (e_merr) void'(merr_q.pop_front());
        chk("mask_err", 136'(mask_err), 136'(e_merr));
        if (!exp_rdy) begin
            idx = DEPTH - init_left;
            chk("sweep_strobe", 136'({ram_cen, ram_gwen, ram_a, ram_wen, ram_d}),
                136'({1'b0, 1'b0, 10'(idx), {DW{1'b0}}, INIT_VAL}));
            init_left--;
            if (init_left == 0) begin
                exp_rdy = 1'b1;
                for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT_VAL;
            end
        end else begin
            if (vld && wr) begin
                chk("wr_strobe", 136'({ram_cen, ram_gwen, ram_a, ram_wen, ram_d}),
                    136'({1'b0, 1'b0, addr, ~wmask, wdata}));
                model_write(addr, wdata, wmask);
                e_merr = use_tbl ? tbl_merr : !mask_uniform(wmask);
                if (e_merr) merr_q.push_back(cyc + 1);
            end else if (vld) begin
                chk("rd_strobe", 136'({ram_cen, ram_gwen, ram_a, ram_wen}),
                    136'({1'b0, 1'b1, addr, {DW{1'b1}}}));
                r.due  = cyc + 2;
                r.data = use_tbl ? tbl_rdata : exp_mem[addr];
                rsp_q.push_back(r);
            end else begin
                chk("idle_strobe", 136'({ram_cen, ram_gwen, ram_wen}), 136'({1'b1, 1'b1, {DW{1'b1}}}));
            end
            if (start) begin
                exp_rdy   = 1'b0;
                init_left = DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        cycle(1'b1, 1'b0, a, '0, '0, 1'b0, 1'b1, e, 1'b0);
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic          exp_merr;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] PAT  = 59'h5_A5A5_A5A5_A5A5_A5;
    localparam logic [DW-1:0] D1   = 59'h2AA_AAAA_AAAA_AAAA;
    localparam logic [DW-1:0] D2   = 59'h0F0_F0F0_F0F0_F0F0;
    localparam logic [DW-1:0] B58  = {1'b1, 58'h0};

    vec_t tbl [12];

    initial begin
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        logic          s;

        tbl[0]  = '{1'b1, 10'h3FF, PAT,  ONES,  1'b0, '0};
        tbl[1]  = '{1'b0, 10'h3FF, '0,   '0,    1'b0, PAT};
        tbl[2]  = '{1'b1, 10'h000, 59'h111, ONES, 1'b0, '0};
        tbl[3]  = '{1'b1, 10'h001, D1,   ONES,  1'b0, '0};
        tbl[4]  = '{1'b1, 10'h002, D2,   ONES,  1'b0, '0};
        tbl[5]  = '{1'b0, 10'h000, '0,   '0,    1'b0, 59'h111};
        tbl[6]  = '{1'b0, 10'h001, '0,   '0,    1'b0, D1};
        tbl[7]  = '{1'b0, 10'h002, '0,   '0,    1'b0, D2};
        tbl[8]  = '{1'b1, 10'h003, ONES, 59'h1, 1'b1, '0};
        tbl[9]  = '{1'b0, 10'h003, '0,   '0,    1'b0, '0};
        tbl[10] = '{1'b1, 10'h003, ONES, B58,   1'b0, '0};
        tbl[11] = '{1'b0, 10'h003, '0,   '0,    1'b0, B58};

        rst_n      = 1'b0;
        init_start = 1'b0;
        req_vld    = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wmask  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 136'(req_rdy), 136'(0));
        chk("rst_init_done", 136'(init_done), 136'(0));
        chk("rst_rsp_vld", 136'(rsp_vld), 136'(0));
        chk("rst_rsp_rdata", 136'(rsp_rdata), 136'(0));
        chk("rst_mask_err", 136'(mask_err), 136'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Power-up sweep, then first READY cycle
        idle(DEPTH + 2);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, 1'b0,
                  1'b1, tbl[i].exp_rdata, tbl[i].exp_merr);
        end
        idle(3);

        // init_start together with an accepted read; requests during the sweep are ignored
        cycle(1'b1, 1'b0, 10'h3FF, '0, '0, 1'b1, 1'b1, PAT, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'($urandom % 2), 1'($urandom % 2), 10'($urandom), 59'({$urandom, $urandom}),
                  ONES, 1'($urandom % 2), 1'b0, '0, 1'b0);
        end
        rd(10'h3FF, INIT_VAL);
        rd(10'h003, INIT_VAL);
        idle(3);

        // Reset in the middle of a sweep restarts it from address 0
        cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
        idle(500);
        @(negedge clk);
        chk("mid_sweep_addr", 136'(ram_a), 136'(500));
        rst_n = 1'b0;
        #1;
        chk("async_rst_addr", 136'(ram_a), 136'(0));
        chk("async_rst_rdy", 136'(req_rdy), 136'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(DEPTH + 2);

        // Random traffic against the reference memory
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom % 10) < 7;
            w = 1'($urandom % 2);
            a = ($urandom % 8 == 0) ? 10'h3FF : 10'($urandom % 16);
            d = 59'({$urandom, $urandom});
            if ($urandom % 5 == 0) m = 59'({$urandom, $urandom});
            else m = {{1{1'($urandom % 2)}}, {29{1'($urandom % 2)}}, {29{1'($urandom % 2)}}};
            s = ($urandom % 700 == 0);
            cycle(v, w, a, d, m, s, 1'b0, '0, 1'b0);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
